mmio_interconnect: RTL and testbench
====================================

Name: mmio_interconnect

Overview:
- Parametrised successor to the fixed three-peripheral bus decoder.
- Routes single-master MemRead/MemWrite accesses to NUM_SLAVES memory-mapped slaves, using per-slave base/mask windows.
- Adds a ready handshake with wait states, a timeout watchdog and a decode-miss detector.
- Faults are recorded in an internal status block, so a stuck or unmapped peripheral cannot hang the pipeline CPU.

Parameters:
- NUM_SLAVES, 4, number of slave ports (1..8).
- SLAVE_BASE, {32'h4000_0020, 32'h4000_0018, 32'h4000_0010, 32'h0000_0000}, NUM_SLAVES*32-bit concatenation; slave i base is bits [32i+31:32i].
- SLAVE_MASK, {32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'hC000_0000}, per-slave compare mask, same packing.
- TIMEOUT, 16, ACCESS cycles without s_ready before abort (≥2).
- STAT_ADDR, 32'h4000_0100, base of internal status block (8 bytes).

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous, active-high reset.
- MemRead, input, 1, master read request; held until Ready.
- MemWrite, input, 1, master write request; held until Ready.
- Address, input, 32, master byte address.
- Write_data, input, 32, master write data.
- Read_data, output, 32, registered read data; valid when Ready=1.
- Ready, output, 1, one-cycle completion pulse.
- s_read, output, NUM_SLAVES, per-slave read strobe.
- s_write, output, NUM_SLAVES, per-slave write strobe.
- s_addr, output, 32, latched address, shared by all slaves.
- s_wdata, output, 32, latched write data, shared by all slaves.
- s_rdata, input, NUM_SLAVES*32, per-slave read data.
- s_ready, input, NUM_SLAVES, per-slave completion.

Behaviour:
- Reset values:
  - FSM=IDLE.
  - Ready=0, Read_data=0.
  - s_read=0, s_write=0, s_addr=0, s_wdata=0.
  - ERR=0, FAULT_ADDR=0, TO_CNT=0, watchdog counter=0.
- Decode:
  - hit[i] = ((Address & MASK[i]) == BASE[i]); the lowest index among hits wins.
  - The status block matches when Address[31:3] == STAT_ADDR[31:3] and takes priority over all slaves.
- Request:
  - Req = MemRead | MemWrite.
  - If both are high, the access is treated as a write.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE, Req, slave hit: latch Address/Write_data/op/sel into s_addr/s_wdata; clear the watchdog; go to ACCESS.
  - IDLE, Req, status hit:
    - Read: capture the status word into Read_data.
    - Write: apply the W1C to ERR.
    - Go to DONE.
  - IDLE, Req, no hit: set ERR[1]; FAULT_ADDR ← Address; Read_data ← 0; write discarded; go to DONE.
  - ACCESS:
    - s_read[sel] or s_write[sel] is held high while in this state; all other strobes are 0.
    - On s_ready[sel]=1: Read_data ← s_rdata[sel] (writes load 0); go to DONE.
    - Otherwise the watchdog increments.
    - When watchdog == TIMEOUT-1 with no ready: drop the strobe; set ERR[0]; FAULT_ADDR ← s_addr; TO_CNT increments (saturates at 255); Read_data ← 32'hFFFF_FFFF; go to DONE.
    - s_ready on the TIMEOUT-1 cycle counts as success, not timeout.
  - DONE: Ready=1 for exactly one cycle; all strobes 0; next state is IDLE.
- Timing:
  - The master sees its request in IDLE regardless of a stale prior Ready.
  - Requests are not sampled in DONE, so back-to-back accesses need 1 idle cycle.
- Latency:
  - Zero-wait slave: 3 cycles from request to Ready (IDLE→ACCESS→DONE).
  - Status and miss accesses: 2 cycles.
  - Timeout: TIMEOUT+2 cycles.
- Status block:
  - +0 reads {16'b0, TO_CNT[7:0], 6'b0, ERR[1:0]}. Writing +0 clears ERR bits where Write_data=1 (W1C); TO_CNT clears only on reset.
  - +4 reads FAULT_ADDR (read-only; writes ignored).
  - FAULT_ADDR tracks the most recent fault.
- Reset mid-ACCESS: strobes drop at the reset edge; the access is abandoned with no Ready pulse; ERR/TO_CNT are cleared.
- s_rdata/s_ready from unselected slaves are ignored.

Test Plan:
- Read 0x0000_0040 with slave0 ready in its first ACCESS cycle, s_rdata0=0x1234_5678 → s_read[0] high 1 cycle, Ready at cycle 3, Read_data=0x1234_5678.
- Write 0x4000_0010, data 0x5, slave1 ready after 3 wait cycles → s_write[1] high 4 cycles with s_wdata=0x5, one Ready pulse, other strobes 0.
- Read 0x4000_0018, slave2 never ready, TIMEOUT=16 → strobe drops after 16 cycles; Ready with 0xFFFF_FFFF; status +0 reads 0x0000_0101; +4 reads 0x4000_0018.
- Read 0x4000_0200 (unmapped) → Ready at cycle 2 with 0; ERR[1] set. Then write 0x2 to 0x4000_0100 → ERR[1] clear, TO_CNT unchanged.
- Reset asserted during slave3 ACCESS wait → strobes 0 next cycle, no Ready, status reads 0 afterwards.
- MemRead=MemWrite=1 to slave0 → s_write[0] asserted, s_read[0] stays 0.

Source files
------------

// File: rtl/mmio_interconnect.sv
// ---------------------------------------------------------------------------
// mmio_interconnect
//
// Purpose:
//   Routes single-master MemRead/MemWrite accesses to NUM_SLAVES
//   memory-mapped slaves. Each slave is selected through a base/mask window.
//   The block provides:
//     - a ready handshake that tolerates slave wait states,
//     - a watchdog that aborts accesses to slaves that never answer,
//     - a decode-miss detector.
//   Faults are logged in a small internal status block, so a dead or
//   unmapped peripheral can never hang the master.
//
// Handshake (master side):
//   The master raises MemRead and/or MemWrite with a stable Address and
//   Write_data, then holds them until it sees Ready=1. Ready is a single-cycle
//   pulse, and Read_data is valid in that same cycle. If MemRead and MemWrite
//   are both high, the access is a write. The request is not sampled while
//   Ready is high, so the master drops it in that cycle and may issue the
//   next access afterwards.
//
// Handshake (slave side):
//   s_read[i] / s_write[i] is held high for the whole access. The slave
//   answers by raising s_ready[i]; in that cycle s_rdata[i] is taken as the
//   read data. Ready and rdata from unselected slaves are ignored.
//
// Ports:
//   clk          - system clock
//   reset        - synchronous active-high reset
//   MemRead      - master read request
//   MemWrite     - master write request
//   Address      - master byte address
//   Write_data   - master write data
//   Read_data    - registered read data, valid with Ready
//   Ready        - one-cycle completion pulse
//   s_read       - per-slave read strobe
//   s_write      - per-slave write strobe
//   s_addr       - latched address, shared by all slaves
//   s_wdata      - latched write data, shared by all slaves
//   s_rdata      - per-slave read data, slave i at [32i+31:32i]
//   s_ready      - per-slave completion
//   o_dbg_state  - current FSM state (0=IDLE, 1=ACCESS, 2=DONE)
//
// Status block (at STAT_ADDR):
//   +0 : {16'b0, TO_CNT[7:0], 6'b0, ERR[1:0]}
//        Writing 1 to an ERR bit clears it. ERR[0] means timeout and
//        ERR[1] means decode miss. TO_CNT clears only on reset.
//   +4 : FAULT_ADDR, the address of the most recent fault (read-only).
// ---------------------------------------------------------------------------
module mmio_interconnect #(
    parameter int                         NUM_SLAVES = 4,
    parameter logic [NUM_SLAVES*32-1:0]   SLAVE_BASE = {32'h4000_0020, 32'h4000_0018,
                                                        32'h4000_0010, 32'h0000_0000},
    parameter logic [NUM_SLAVES*32-1:0]   SLAVE_MASK = {32'hFFFF_FFF8, 32'hFFFF_FFF8,
                                                        32'hFFFF_FFFC, 32'hC000_0000},
    parameter int                         TIMEOUT    = 16,
    parameter logic [31:0]                STAT_ADDR  = 32'h4000_0100
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       MemRead,
    input  logic                       MemWrite,
    input  logic [31:0]                Address,
    input  logic [31:0]                Write_data,
    output logic [31:0]                Read_data,
    output logic                       Ready,
    output logic [NUM_SLAVES-1:0]      s_read,
    output logic [NUM_SLAVES-1:0]      s_write,
    output logic [31:0]                s_addr,
    output logic [31:0]                s_wdata,
    input  logic [NUM_SLAVES*32-1:0]   s_rdata,
    input  logic [NUM_SLAVES-1:0]      s_ready,
    output logic [1:0]                 o_dbg_state
);

    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int WD_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                  r_state;
    logic [31:0]             r_rdata;
    logic                    r_ready;
    logic [NUM_SLAVES-1:0]   r_s_read;
    logic [NUM_SLAVES-1:0]   r_s_write;
    logic [31:0]             r_s_addr;
    logic [31:0]             r_s_wdata;
    logic [SEL_W-1:0]        r_sel;
    logic                    r_is_write;
    logic [WD_W-1:0]         r_wd;
    logic [1:0]              r_err;
    logic [31:0]             r_fault_addr;
    logic [7:0]              r_to_cnt;

    logic                    w_req;
    logic                    w_stat_hit;
    logic                    w_any_hit;
    logic [SEL_W-1:0]        w_sel;
    logic [NUM_SLAVES-1:0]   w_onehot;
    logic                    w_sel_ready;
    logic [31:0]             w_sel_rdata;
    logic [31:0]             w_stat_word;

    assign w_req      = MemRead | MemWrite;
    assign w_stat_hit = (Address[31:3] == STAT_ADDR[31:3]);

    // Descending scan, so the lowest matching index is the one left in w_sel.
    always_comb begin
        w_any_hit = 1'b0;
        w_sel     = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((Address & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
                w_any_hit = 1'b1;
                w_sel     = SEL_W'(i);
            end
        end
    end

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (w_sel == SEL_W'(i)) begin
                w_onehot[i] = 1'b1;
            end
        end
    end

    // Only the latched slave's ready/rdata are observed.
    always_comb begin
        w_sel_ready = 1'b0;
        w_sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (r_sel == SEL_W'(i)) begin
                w_sel_ready = s_ready[i];
                w_sel_rdata = s_rdata[32*i +: 32];
            end
        end
    end

    assign w_stat_word = {16'b0, r_to_cnt, 6'b0, r_err};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_rdata      <= '0;
            r_ready      <= 1'b0;
            r_s_read     <= '0;
            r_s_write    <= '0;
            r_s_addr     <= '0;
            r_s_wdata    <= '0;
            r_sel        <= '0;
            r_is_write   <= 1'b0;
            r_wd         <= '0;
            r_err        <= '0;
            r_fault_addr <= '0;
            r_to_cnt     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ready <= 1'b0;
                    if (w_req) begin
                        if (w_stat_hit) begin
                            // The status block answers locally, so no slave
                            // strobe is raised.
                            if (MemWrite) begin
                                if (!Address[2]) begin
                                    r_err <= r_err & ~Write_data[1:0];
                                end
                                r_rdata <= '0;
                            end else begin
                                r_rdata <= Address[2] ? r_fault_addr : w_stat_word;
                            end
                            r_ready <= 1'b1;
                            r_state <= DONE;
                        end else if (w_any_hit) begin
                            r_s_addr   <= Address;
                            r_s_wdata  <= Write_data;
                            r_sel      <= w_sel;
                            r_is_write <= MemWrite;
                            r_wd       <= '0;
                            r_s_write  <= MemWrite ? w_onehot : '0;
                            r_s_read   <= MemWrite ? '0 : w_onehot;
                            r_state    <= ACCESS;
                        end else begin
                            // Decode miss: log it and complete with zero data.
                            r_err[1]     <= 1'b1;
                            r_fault_addr <= Address;
                            r_rdata      <= '0;
                            r_ready      <= 1'b1;
                            r_state      <= DONE;
                        end
                    end
                end

                ACCESS: begin
                    if (w_sel_ready) begin
                        r_rdata   <= r_is_write ? 32'h0 : w_sel_rdata;
                        r_s_read  <= '0;
                        r_s_write <= '0;
                        r_ready   <= 1'b1;
                        r_state   <= DONE;
                    end else if (r_wd == WD_LAST) begin
                        // Watchdog expiry: abandon the slave and complete with
                        // all-ones so the master can tell it from real data.
                        r_s_read     <= '0;
                        r_s_write    <= '0;
                        r_err[0]     <= 1'b1;
                        r_fault_addr <= r_s_addr;
                        if (r_to_cnt != 8'hFF) begin
                            r_to_cnt <= r_to_cnt + 8'd1;
                        end
                        r_rdata <= 32'hFFFF_FFFF;
                        r_ready <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end

                DONE: begin
                    r_ready <= 1'b0;
                    r_state <= IDLE;
                end

                default: begin
                    r_ready   <= 1'b0;
                    r_s_read  <= '0;
                    r_s_write <= '0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign Read_data   = r_rdata;
    assign Ready       = r_ready;
    assign s_read      = r_s_read;
    assign s_write     = r_s_write;
    assign s_addr      = r_s_addr;
    assign s_wdata     = r_s_wdata;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mmio_interconnect.sv
module tb_mmio_interconnect;

  localparam int NS = 4;

  logic          clk;
  logic          reset;
  logic          MemRead;
  logic          MemWrite;
  logic [31:0]   Address;
  logic [31:0]   Write_data;
  logic [31:0]   Read_data;
  logic          Ready;
  logic [NS-1:0] s_read;
  logic [NS-1:0] s_write;
  logic [31:0]   s_addr;
  logic [31:0]   s_wdata;
  logic [NS*32-1:0] s_rdata;
  logic [NS-1:0] s_ready;
  logic [1:0]    o_dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // slave models: configurable wait count and read value
  int          wait_cfg [NS];
  logic [31:0] rd_val   [NS];
  int          busy_cnt [NS];

  // per-transaction observations
  int          rd_cnt [NS];
  int          wr_cnt [NS];
  logic [31:0] seen_wdata;

  mmio_interconnect dut (
    .clk         (clk),
    .reset       (reset),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .Address     (Address),
    .Write_data  (Write_data),
    .Read_data   (Read_data),
    .Ready       (Ready),
    .s_read      (s_read),
    .s_write     (s_write),
    .s_addr      (s_addr),
    .s_wdata     (s_wdata),
    .s_rdata     (s_rdata),
    .s_ready     (s_ready),
    .o_dbg_state (o_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // slave models
  always @(posedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (s_read[i] || s_write[i]) busy_cnt[i] <= busy_cnt[i] + 1;
      else                         busy_cnt[i] <= 0;
    end
  end

  always_comb begin
    s_ready = '0;
    s_rdata = '0;
    for (int i = 0; i < NS; i++) begin
      s_ready[i]         = (s_read[i] || s_write[i]) && (busy_cnt[i] >= wait_cfg[i]);
      s_rdata[32*i +: 32] = rd_val[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one access and waits (bounded) for Ready; lat counts the request
  // cycle as cycle 1. One idle cycle follows before returning.
  task automatic xact(input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wd, output int lat, output logic [31:0] data);
    int  edges;
    logic seen;
    for (int i = 0; i < NS; i++) begin
      rd_cnt[i] = 0;
      wr_cnt[i] = 0;
    end
    seen_wdata = 32'hx;
    MemRead    = rd;
    MemWrite   = wr;
    Address    = addr;
    Write_data = wd;
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 40) begin
      @(posedge clk);
      @(negedge clk);
      edges++;
      for (int i = 0; i < NS; i++) begin
        if (s_read[i])  rd_cnt[i]++;
        if (s_write[i]) begin
          wr_cnt[i]++;
          seen_wdata = s_wdata;
        end
      end
      if (Ready) seen = 1'b1;
    end
    check("ready_seen", {31'b0, seen}, 32'd1);
    data     = Read_data;
    lat      = edges + 1;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    @(negedge clk);
    check("ready_one_cycle", {31'b0, Ready}, 32'd0);
  endtask

  initial begin
    int          lat;
    logic [31:0] d;

    for (int i = 0; i < NS; i++) begin
      wait_cfg[i] = 0;
      rd_val[i]   = 32'hA000_0000 + i;
    end
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    Address    = '0;
    Write_data = '0;
    reset      = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);

    check("rst_ready",   {31'b0, Ready}, 32'd0);
    check("rst_rdata",   Read_data, 32'd0);
    check("rst_s_read",  {28'b0, s_read}, 32'd0);
    check("rst_s_write", {28'b0, s_write}, 32'd0);
    check("rst_s_addr",  s_addr, 32'd0);
    check("rst_s_wdata", s_wdata, 32'd0);
    check("rst_state",   {30'b0, o_dbg_state}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // zero-wait read from slave0
    rd_val[0] = 32'h1234_5678;
    xact(1'b1, 1'b0, 32'h0000_0040, 32'h0, lat, d);
    check("s0_rd_lat",   lat, 32'd3);
    check("s0_rd_data",  d, 32'h1234_5678);
    check("s0_rd_strb",  rd_cnt[0], 32'd1);
    check("s0_rd_saddr", s_addr, 32'h0000_0040);

    // write to slave1 with 3 wait states
    wait_cfg[1] = 3;
    xact(1'b0, 1'b1, 32'h4000_0010, 32'h5, lat, d);
    check("s1_wr_lat",   lat, 32'd6);
    check("s1_wr_strb",  wr_cnt[1], 32'd4);
    check("s1_wr_wdata", seen_wdata, 32'h5);
    check("s1_wr_other", rd_cnt[0] + rd_cnt[1] + rd_cnt[2] + rd_cnt[3]
                         + wr_cnt[0] + wr_cnt[2] + wr_cnt[3], 32'd0);
    check("s1_wr_rdata", d, 32'h0);

    // slave2 never answers: watchdog abort
    wait_cfg[2] = 1000;
    xact(1'b1, 1'b0, 32'h4000_0018, 32'h0, lat, d);
    check("to_lat",   lat, 32'd18);
    check("to_strb",  rd_cnt[2], 32'd16);
    check("to_rdata", d, 32'hFFFF_FFFF);
    xact(1'b1, 1'b0, 32'h4000_0100, 32'h0, lat, d);
    check("stat_lat",  lat, 32'd2);
    check("stat0_to",  d, 32'h0000_0101);
    xact(1'b1, 1'b0, 32'h4000_0104, 32'h0, lat, d);
    check("stat4_to",  d, 32'h4000_0018);

    // unmapped read
    xact(1'b1, 1'b0, 32'h4000_0200, 32'h0, lat, d);
    check("miss_lat",   lat, 32'd2);
    check("miss_rdata", d, 32'h0);
    xact(1'b1, 1'b0, 32'h4000_0100, 32'h0, lat, d);
    check("stat0_miss", d, 32'h0000_0103);
    xact(1'b1, 1'b0, 32'h4000_0104, 32'h0, lat, d);
    check("stat4_miss", d, 32'h4000_0200);

    // W1C of ERR[1], TO_CNT kept
    xact(1'b0, 1'b1, 32'h4000_0100, 32'h2, lat, d);
    xact(1'b1, 1'b0, 32'h4000_0100, 32'h0, lat, d);
    check("w1c_err1", d, 32'h0000_0101);
    xact(1'b0, 1'b1, 32'h4000_0100, 32'h1, lat, d);
    xact(1'b1, 1'b0, 32'h4000_0100, 32'h0, lat, d);
    check("w1c_err0", d, 32'h0000_0100);

    // FAULT_ADDR is read-only
    xact(1'b0, 1'b1, 32'h4000_0104, 32'hDEAD_BEEF, lat, d);
    xact(1'b1, 1'b0, 32'h4000_0104, 32'h0, lat, d);
    check("fault_ro", d, 32'h4000_0200);

    // read+write together is a write
    xact(1'b1, 1'b1, 32'h0000_0008, 32'h77, lat, d);
    check("rw_wr_strb", wr_cnt[0], 32'd1);
    check("rw_rd_strb", rd_cnt[0], 32'd0);
    check("rw_wdata",   seen_wdata, 32'h77);

    // reset in the middle of a slave3 wait
    wait_cfg[3] = 1000;
    MemRead  = 1'b1;
    MemWrite = 1'b0;
    Address  = 32'h4000_0020;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("mid_s_read", {28'b0, s_read}, 32'h8);
    reset   = 1'b1;
    MemRead = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_strb",  {28'b0, s_read | s_write}, 32'd0);
    check("mid_rst_ready", {31'b0, Ready}, 32'd0);
    check("mid_rst_state", {30'b0, o_dbg_state}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_noready", {31'b0, Ready}, 32'd0);
    xact(1'b1, 1'b0, 32'h4000_0100, 32'h0, lat, d);
    check("post_rst_stat0", d, 32'h0);
    xact(1'b1, 1'b0, 32'h4000_0104, 32'h0, lat, d);
    check("post_rst_stat4", d, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
